// File: rtl/alu_pkg.sv
// Shared types and constants for the start/done ALU and its command-side driver.
package alu_pkg;

  localparam int RESULT_W  = 16;
  localparam int OPERAND_W = 8;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_RESP
  } alu_drv_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_MUL;
  endfunction

  function automatic logic op_uses_alu(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/alu_drv_timeout.sv
// Loadable 8-bit ISSUE-phase watchdog: cleared to zero, counts while enabled,
// flags expiry during the LIMIT-th enabled cycle.
module alu_drv_timeout #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/alu_driver.sv
// Command-side initiator for the start/done ALU: command handshake, issue, drain of done,
// response handshake. Optional ISSUE watchdog enabled by defining ALU_DRV_TIMEOUT_EN.
module alu_driver
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic [15:0] alu_result,
  input  logic        alu_done
);

  alu_drv_state_e state_q, state_d;
  logic [OPERAND_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic [RESULT_W-1:0]  result_q, result_d;
  logic                 err_q, err_d;
  logic                 live_q;
  logic                 timeout_hit;

`ifdef ALU_DRV_TIMEOUT_EN
  alu_drv_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q != ST_ISSUE),
    .enable_i  (state_q == ST_ISSUE),
    .expired_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_d  = cmd_a;
          b_d  = cmd_b;
          op_d = cmd_op;
          if (op_uses_alu(cmd_op)) begin
            state_d = ST_ISSUE;
          end else begin
            // Non-ALU ops pass through DRAIN so the response lands one cycle later,
            // matching the two-cycle NO_OP/illegal turnaround.
            state_d  = ST_DRAIN;
            result_d = '0;
            err_d    = !op_is_legal(cmd_op);
          end
        end
      end
      ST_ISSUE: begin
        if (alu_done) begin
          result_d = alu_result;
          err_d    = 1'b0;
          state_d  = ST_DRAIN;
        end else if (timeout_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!alu_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign cmd_ready  = (state_q == ST_IDLE) && live_q;
  assign alu_start  = (state_q == ST_ISSUE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: behavioural start/done ALU, vector table,
// randomized ops, reset-abort sequence, and watchdog cases when ALU_DRV_TIMEOUT_EN is set.
module tb_alu_driver;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic [15:0] alu_result;
  logic        alu_done;

  int checks = 0;
  int errors = 0;

  // Behaviour of the attached ALU
  int   alu_lat  = 0;
  int   alu_hold = 2;
  logic alu_dead = 1'b0;

  always #5 clk = ~clk;

  alu_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .alu_done   (alu_done)
  );

  // Start/done ALU: done rises alu_lat cycles after start is seen, stays for alu_hold cycles.
  int alu_phase;
  int alu_wait;
  int alu_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_done   <= 1'b0;
      alu_result <= 16'h0;
      alu_phase  <= 0;
      alu_wait   <= 0;
      alu_cnt    <= 0;
    end else begin
      case (alu_phase)
        0: if (alu_start && !alu_dead) begin
          case (alu_op)
            3'd1: alu_result <= 16'(alu_a) + 16'(alu_b);
            3'd2: alu_result <= {8'h00, alu_a & alu_b};
            3'd3: alu_result <= {8'h00, alu_a ^ alu_b};
            3'd4: alu_result <= 16'(alu_a) * 16'(alu_b);
            default: alu_result <= 16'hDEAD;
          endcase
          if (alu_lat == 0) begin
            alu_done  <= 1'b1;
            alu_cnt   <= alu_hold;
            alu_phase <= 2;
          end else begin
            alu_wait  <= alu_lat - 1;
            alu_phase <= 1;
          end
        end
        1: if (alu_wait == 0) begin
          alu_done  <= 1'b1;
          alu_cnt   <= alu_hold;
          alu_phase <= 2;
        end else begin
          alu_wait <= alu_wait - 1;
        end
        default: if (alu_cnt <= 1) begin
          alu_done  <= 1'b0;
          alu_phase <= 0;
        end else begin
          alu_cnt <= alu_cnt - 1;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what the response must be for a command, from the opcode table.
  task automatic ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic [15:0] res, output logic err);
    int ai, bi;
    ai = a;
    bi = b;
    err = 1'b0;
    case (op)
      3'd0: res = 16'h0;
      3'd1: res = 16'(ai + bi);
      3'd2: res = 16'(ai & bi);
      3'd3: res = 16'(ai ^ bi);
      3'd4: res = 16'(ai * bi);
      default: begin res = 16'h0; err = 1'b1; end
    endcase
    if (alu_dead && op >= 3'd1 && op <= 3'd4) begin
      res = 16'h0;
      err = 1'b1;
    end
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after the response.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int stall);
    int guard, cyc, st_first, st_last, rsp_cyc;
    int exp_first, exp_last, exp_rsp, drain_end;
    logic [15:0] exp_res;
    logic exp_err;
    ref_model(op, a, b, exp_res, exp_err);
    if (op == 3'd0 || op > 3'd4) begin
      exp_first = -1; exp_last = -1; exp_rsp = 2;
    end else if (alu_dead) begin
      exp_first = 1; exp_last = TO; exp_rsp = TO + 2;
    end else begin
      exp_first = 1;
      exp_last  = 2 + alu_lat;
      drain_end = (3 + alu_lat > 2 + alu_lat + alu_hold) ? 3 + alu_lat : 2 + alu_lat + alu_hold;
      exp_rsp   = drain_end + 1;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom);
    cmd_b = 8'($urandom);
    cmd_op = 3'($urandom);
    cyc = 1; st_first = -1; st_last = -1; rsp_cyc = -1;
    while (cyc < 60) begin
      if (alu_start) begin
        if (st_first < 0) begin
          st_first = cyc;
          chk("alu_a", 32'(alu_a), 32'(a));
          chk("alu_b", 32'(alu_b), 32'(b));
          chk("alu_op", 32'(alu_op), 32'(op));
        end
        st_last = cyc;
      end
      if (rsp_valid) begin
        rsp_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("start_first", 32'(st_first), 32'(exp_first));
    chk("start_last", 32'(st_last), 32'(exp_last));
    chk("rsp_cycle", 32'(rsp_cyc), 32'(exp_rsp));
    if (rsp_cyc < 0) return;
    for (int i = 0; i < stall; i++) begin
      chk("stall_result", 32'(rsp_result), 32'(exp_res));
      chk("stall_err", 32'(rsp_err), 32'(exp_err));
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk("rsp_result", 32'(rsp_result), 32'(exp_res));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    $display("op=%0d a=%02h b=%02h stall=%0d -> result=%04h err=%0b rsp_cycle=%0d (expect %04h/%0b @%0d)",
             op, a, b, stall, rsp_result, rsp_err, rsp_cyc, exp_res, exp_err, exp_rsp);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    int         hold;
    int         stall;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int bad;
    vecs[0] = '{3'd1, 8'd200, 8'd100, 0, 2, 0};
    vecs[1] = '{3'd4, 8'd255, 8'd255, 0, 2, 0};
    vecs[2] = '{3'd3, 8'hF0, 8'h0F, 0, 2, 0};
    vecs[3] = '{3'd0, 8'h12, 8'h34, 0, 2, 0};
    vecs[4] = '{3'd7, 8'h56, 8'h78, 0, 2, 0};
    vecs[5] = '{3'd1, 8'h01, 8'h02, 0, 2, 3};
    vecs[6] = '{3'd2, 8'hAA, 8'h0F, 1, 1, 0};
    vecs[7] = '{3'd5, 8'h9A, 8'hBC, 0, 2, 1};
    vecs[8] = '{3'd3, 8'h55, 8'hFF, 3, 3, 0};
    vecs[9] = '{3'd4, 8'd16, 8'd16, 2, 2, 0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_alu_ops", {8'h0, alu_a, alu_b, 5'h0, alu_op}, 32'd0);
    reset = 1'b0;
    chk("release_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("first_edge_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      alu_lat  = vecs[i].lat;
      alu_hold = vecs[i].hold;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall);
    end

    // Reset asserted while alu_start is high aborts the op with no response
    alu_lat = 3;
    alu_hold = 2;
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    cmd_a = 8'd7;
    cmd_b = 8'd9;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_start_pre", 32'(alu_start), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_start_drop", 32'(alu_start), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || alu_start) bad++;
    end
    chk("abort_no_response", 32'(bad), 32'd0);
    alu_lat = 0;
    run_op(3'd1, 8'd200, 8'd100, 0);

`ifdef ALU_DRV_TIMEOUT_EN
    alu_dead = 1'b1;
    run_op(3'd1, 8'd3, 8'd4, 0);
    alu_dead = 1'b0;
    alu_lat = TO - 2;
    alu_hold = 2;
    run_op(3'd4, 8'd12, 8'd13, 0);
`endif

    for (int i = 0; i < 30; i++) begin
      alu_lat  = $urandom_range(0, 3);
      alu_hold = $urandom_range(1, 3);
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_driver.md
# alu_driver

Command-side initiator for the team's start/done ALU. Accepts one operation per valid/ready handshake, drives operands, opcode and `start` to the ALU, and waits for `done`. It then captures the 16-bit result, waits for `done` to fall, and returns the result on a valid/ready response port. It sits between the test or sequencer fabric and the ALU instance.

## Interface
- `TIMEOUT_CYCLES`, 8: cycles `alu_start` may stay high without `alu_done` before the op is aborted (only used with timeout enabled; legal range 1–255).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_a`, `cmd_b`  in  8 each  operands.
- `cmd_op`  in  3  opcode.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_result`  out  16  captured result.
- `rsp_err`  out  1  illegal opcode or timeout.
- `alu_a`, `alu_b`  out  8 each  registered operands to ALU.
- `alu_op`  out  3  registered opcode to ALU.
- `alu_start`  out  1  ALU start.
- `alu_result`  in  16  ALU result.
- `alu_done`  in  1  ALU done.

## Operation
- Opcodes: NO_OP=0, ADD=1, AND=2, XOR=3, MUL=4. Values 5–7 are illegal.
- States:
  - IDLE: `cmd_ready`=1. On handshake, register a/b/op.
    - ADD/AND/XOR/MUL go to ISSUE.
    - NO_OP goes to RESP with result 0, err 0.
    - Illegal opcode goes to RESP with result 0, err 1. The ALU is never started.
  - ISSUE: `alu_start`=1. When `alu_done`=1, capture `alu_result` and go to DRAIN.
  - DRAIN: `alu_start`=0. Stay until `alu_done`=0, then go to RESP. This prevents a stale `done` from completing the next op.
  - RESP: `rsp_valid`=1. `rsp_result`/`rsp_err` are held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `alu_a`/`alu_b`/`alu_op` keep their last values outside ISSUE. Only `alu_start` qualifies them.
- `rsp_result` equals `alu_result` verbatim. The block performs no arithmetic.
- Reset values: `alu_start`, `rsp_valid`, `rsp_err` = 0; `cmd_ready` = 0 during reset and 1 from the first edge after release; `alu_a`, `alu_b`, `alu_op`, `rsp_result` = 0; state = IDLE; timeout counter = 0.
- Reset asserted mid-operation: immediate return to IDLE with `alu_start`=0, and the in-flight op is discarded. At integration, ALU `reset_n` is tied to `~reset`.

## Timing
- Cycle 0: command handshake.
- Cycle 1: `alu_start`=1.
- Cycle 2: `alu_done` seen; result captured at the end of the cycle.
- Cycle 3: `alu_start`=0 and `done` is still high.
- Cycle 4: `done` is low, so the block goes to RESP.
- Cycle 5: `rsp_valid`=1.
- Minimum 6 cycles per ALU op at `rsp_ready`=1. The next `cmd_ready` comes the cycle after the response handshake.
- NO_OP and illegal opcode: `rsp_valid` in cycle 2. The handshake completes the op and `cmd_ready` returns in the next cycle.
- `alu_done` arriving later than cycle 2 is tolerated. ISSUE waits, subject to the timeout.
- `alu_done` high on ISSUE entry (stale) cannot occur because DRAIN guarantees it is low.

## Configuration
- `ALU_DRV_TIMEOUT_EN` defined:
  - An 8-bit counter runs in ISSUE, clearing on entry.
  - When it reaches `TIMEOUT_CYCLES` with no `done`, the block drops `alu_start`, sets result to 0 and err to 1, and goes to DRAIN.
  - `done` arriving in the same cycle the limit is reached wins: the op completes normally.
- Not defined: there is no counter, and ISSUE waits on `done` indefinitely.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum (3-bit opcodes above).
  - `alu_drv_state_e` enum (IDLE, ISSUE, DRAIN, RESP).
  - Constants for the result width (16) and operand width (8).
- One sub-module, `alu_drv_timeout`: a loadable 8-bit counter with `clear`/`enable`/`expired`. It is instantiated only under `ALU_DRV_TIMEOUT_EN`.

## Test plan
- ADD a=200, b=100 with `rsp_ready`=1: `rsp_result`=0x012C and err=0. `alu_start` is high in cycles 1–2 only, and `rsp_valid` is high in cycle 5.
- MUL a=255, b=255: `rsp_result`=0xFE01. Back-to-back XOR 0xF0^0x0F issued on the next `cmd_ready` gives 0x00FF, not the stale 0xFE01.
- NO_OP and then opcode 7: `alu_start` never rises. The responses are 0/err=0 and 0/err=1, each with `rsp_valid` in cycle 2.
- With `rsp_ready` low for 3 cycles after `rsp_valid`: result and err are held stable, `cmd_ready` stays 0, and the block returns to IDLE the cycle after `rsp_ready` rises.
- With `ALU_DRV_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8 and `alu_done` tied 0: `alu_start` falls after 8 ISSUE cycles and the response is 0/err=1.
- `reset` asserted in cycle 1 of an ADD: `alu_start` and `rsp_valid` drop immediately (asynchronously). No response is produced, and the next command is accepted normally after release.
